// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver feeding the PWM command parser through a one-entry
// valid/ready holding register; flags false starts, framing errors and overruns.
module uart_rx_ctrl #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun_err
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (CLKS_PER_BIT < 8) begin : g_bad_baud
        $error("uart_rx_ctrl: CLK_FREQ/BAUD must be at least 8");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             deliver_q, deliver_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_err_q, overrun_err_d;
    logic             rx_s;

    // sync_q[1] is the metastability-safe copy of the line; nothing else looks at rx.
    assign rx_s = sync_q[1];

    always_comb begin
        state_d       = state_q;
        sync_d        = {sync_q[0], rx};
        cnt_d         = cnt_q + CNT_ONE;
        idx_d         = idx_q;
        shift_d       = shift_q;
        deliver_d     = 1'b0;
        frame_err_d   = 1'b0;
        overrun_err_d = 1'b0;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = S_DATA;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                // Returning to IDLE at mid stop bit leaves half a bit to catch a
                // start bit that follows with no idle gap.
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        deliver_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        // A byte may replace the held one only if the consumer takes the old one on this edge.
        if (deliver_q) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            sync_q        <= 2'b11;
            cnt_q         <= '0;
            idx_q         <= 3'd0;
            shift_q       <= 8'h00;
            deliver_q     <= 1'b0;
            rx_data_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            deliver_q     <= deliver_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: stimulus pushes expected bytes, a monitor
// pops them on every accepted rx_valid/rx_ready handshake.
module tb_uart_rx_ctrl;

    localparam int CPB  = 434;
    localparam int HALF = 217;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       busy;
    logic       frame_err;
    logic       overrun_err;

    uart_rx_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .busy        (busy),
        .frame_err   (frame_err),
        .overrun_err (overrun_err)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         acc_cnt = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         busy_cnt = 0;
    int         stab_err = 0;
    int         rise_cyc = 0;
    int         start_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Called on a falling edge; returns on a falling edge so frames can abut.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit expect_it);
        if (expect_it) exp_q.push_back(b);
        start_cyc = cyc;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: samples mid low phase, away from the rising edge.
    initial begin : monitor
        logic       prev_valid;
        logic       prev_held;
        logic [7:0] prev_data;
        logic [7:0] e;
        prev_valid = 1'b0;
        prev_held  = 1'b0;
        prev_data  = 8'h00;
        forever begin
            @(negedge clk);
            #5;
            if (rx_valid && !prev_valid) rise_cyc = cyc;
            if (prev_held && rx_valid && rx_data !== prev_data) stab_err++;
            if (frame_err) fe_cnt++;
            if (overrun_err) ov_cnt++;
            if (busy) busy_cnt++;
            if (rx_valid && rx_ready) begin
                checks++;
                acc_cnt++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte: got 0x%02h, expected no byte", rx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (rx_data !== e) begin
                        errors++;
                        $display("FAIL rx_byte: got 0x%02h, expected 0x%02h", rx_data, e);
                    end
                end
            end
            prev_held  = rx_valid && !rx_ready;
            prev_data  = rx_data;
            prev_valid = rx_valid;
        end
    end

    initial begin : stimulus
        int acc0;
        logic [7:0] stream [5];
        logic [7:0] v55;
        stream[0] = 8'h48; stream[1] = 8'h45; stream[2] = 8'h4C;
        stream[3] = 8'h50; stream[4] = 8'h0A;

        rx       = 1'b1;
        rx_ready = 1'b1;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        check("reset_busy", busy, 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rx_data", rx_data, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_overrun_err", overrun_err, 0);

        // Reset mid-frame: start bit plus three data bits of 0x55.
        v55 = 8'h55;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = v55[i];
            repeat (CPB) @(negedge clk);
        end
        rst_n = 1'b0;
        rx    = 1'b1;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        check("midreset_busy", busy, 0);
        check("midreset_rx_valid", rx_valid, 0);
        fe_cnt = 0;
        ov_cnt = 0;
        acc0 = acc_cnt;
        idle(5);
        send_frame(8'h41, 1'b1, 1'b1);
        idle(20);
        check("midreset_bytes", acc_cnt - acc0, 1);
        check("midreset_flags", fe_cnt + ov_cnt, 0);

        // Single byte with latency.
        acc0 = acc_cnt;
        send_frame(8'h48, 1'b1, 1'b1);
        idle(20);
        check("single_bytes", acc_cnt - acc0, 1);
        check_range("single_latency", rise_cyc - start_cyc, 2 + HALF + 9 * CPB + 1, 2 + HALF + 9 * CPB + 3);
        check("single_flags", fe_cnt + ov_cnt, 0);

        // Back-to-back "HELP\n".
        acc0 = acc_cnt;
        for (int i = 0; i < 5; i++) send_frame(stream[i], 1'b1, 1'b1);
        idle(20);
        check("stream_bytes", acc_cnt - acc0, 5);
        check("stream_flags", fe_cnt + ov_cnt, 0);

        // Backpressure and overrun.
        rx_ready = 1'b0;
        acc0 = acc_cnt;
        stab_err = 0;
        send_frame(8'h31, 1'b1, 1'b1);
        send_frame(8'h32, 1'b1, 1'b0);
        idle(10);
        check("bp_overrun_pulses", ov_cnt, 1);
        check("bp_rx_valid_held", rx_valid, 1);
        check("bp_rx_data_held", rx_data, 8'h31);
        check("bp_data_stable", stab_err, 0);
        check("bp_no_accept", acc_cnt - acc0, 0);
        rx_ready = 1'b1;
        idle(2);
        check("bp_rx_valid_fall", rx_valid, 0);
        check("bp_accepted", acc_cnt - acc0, 1);

        // Framing error followed by a held-low line.
        fe_cnt = 0;
        ov_cnt = 0;
        acc0 = acc_cnt;
        send_frame(8'hA5, 1'b0, 1'b0);
        idle(3 * CPB);
        check("fe_busy_while_low", busy, 1);
        check("fe_pulses", fe_cnt, 1);
        rx = 1'b1;
        idle(10);
        check("fe_busy_after_high", busy, 0);
        send_frame(8'h5A, 1'b1, 1'b1);
        idle(20);
        check("fe_recovery_bytes", acc_cnt - acc0, 1);
        check("fe_pulses_final", fe_cnt, 1);
        check("fe_no_overrun", ov_cnt, 0);

        // Quarter-bit glitch.
        fe_cnt = 0;
        acc0 = acc_cnt;
        busy_cnt = 0;
        rx = 1'b0;
        idle(CPB / 4);
        rx = 1'b1;
        idle(400);
        check("glitch_idle", busy, 0);
        check_range("glitch_busy_cycles", busy_cnt, 1, HALF + 3);
        check("glitch_no_frame_err", fe_cnt, 0);
        check("glitch_no_byte", acc_cnt - acc0, 0);

        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side UART controller for the PWM command path: deserialises 8N1 frames arriving on the `rx` pin into bytes.
- Delivers each byte through a one-entry valid/ready holding register to the command parser that drives `pwm_out`.
- It is the far end of the host byte stream (e.g. "HELP\n").
- Detects false starts, framing errors and overruns.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (434), clock cycles per bit; derived localparam, must be >= 8.

Ports:
- clk  input  1  system clock, 50 MHz, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- rx  input  1  asynchronous serial line, idle high.
- rx_data  output  8  received byte, valid while rx_valid=1.
- rx_valid  output  1  holding register full.
- rx_ready  input  1  consumer accepts byte when rx_valid & rx_ready at a clock edge.
- busy  output  1  frame reception in progress (state != IDLE).
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun_err  output  1  one-cycle pulse: byte completed while holding register full.

Behaviour:
- Reset: synchronous; rst_n=0 at a rising edge clears everything, including mid-frame. After reset: rx_data=0, rx_valid=0, busy=0, frame_err=0, overrun_err=0, state=IDLE, both synchroniser flops=1.
- Synchroniser: rx passes through 2 flops; rx_s is the second flop. All decisions use rx_s only.
- Bit counter: counts 0..CLKS_PER_BIT-1. A bit index 0..7 counts data bits.
- IDLE:
  - rx_s=0 -> START, counter cleared.
- START:
  - When counter reaches CLKS_PER_BIT/2-1 (mid start bit), sample rx_s.
  - rx_s=0 -> DATA, counter cleared, index=0.
  - rx_s=1 -> false start: back to IDLE, no flags.
- DATA:
  - Each time counter reaches CLKS_PER_BIT-1, sample rx_s into the shift register, LSB first (shift right, new bit into bit 7).
  - After index 7 is sampled -> STOP.
- STOP:
  - At counter CLKS_PER_BIT-1, sample rx_s.
  - rx_s=1 -> deliver byte, -> IDLE.
  - rx_s=0 -> frame_err pulse for 1 cycle, byte discarded, -> WAIT_HIGH.
- WAIT_HIGH:
  - Remain until rx_s=1, then -> IDLE.
  - Prevents a held-low line (break) from retriggering.
- Delivery, on the cycle after the stop sample:
  - If rx_valid=0, or rx_valid=1 and rx_ready=1 that same cycle: rx_data <= shift register, rx_valid <= 1.
  - Otherwise overrun_err pulses 1 cycle. The new byte is dropped; the old rx_data and rx_valid are retained.
- Handshake:
  - rx_valid deasserts the cycle after an accepting edge (rx_valid & rx_ready), unless a new byte is delivered on that same edge, in which case it stays 1 with the new data.
  - rx_data is stable while rx_valid=1 and not accepted.
- Latency:
  - Stop-bit sample occurs 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles (±1) after the first low cycle at the rx pin.
  - rx_valid rises the following cycle.
- Back-to-back frames: IDLE is re-entered at mid stop bit, so a start bit immediately following the stop bit is caught. Baud mismatch tolerance is ±4% minimum.
- busy=1 in START, DATA, STOP, WAIT_HIGH.

Test Plan:
- Reset mid-frame:
  - Stimulus: drive start bit plus 3 data bits of 0x55, pulse rst_n=0 for 2 cycles, release with rx=1.
  - Required: busy=0, rx_valid=0, no flags, next valid frame 0x41 received correctly.
- Single byte:
  - Stimulus: send 0x48 ("H") at 115200 baud, rx_ready=1.
  - Required: exactly one rx_valid pulse with rx_data=0x48, arriving within latency ±1 cycle; frame_err=overrun_err=0.
- Stream:
  - Stimulus: send "HELP\n" back-to-back (no idle gap), rx_ready=1.
  - Required: rx_data sequence 0x48,0x45,0x4C,0x50,0x0A, five valid pulses, no errors.
- Backpressure/overrun:
  - Stimulus: rx_ready=0, send 0x31 then 0x32.
  - Required: rx_valid held with rx_data=0x31 throughout, overrun_err pulses once at the second delivery.
  - Then raise rx_ready: 0x31 accepted, rx_valid falls.
- Framing error:
  - Stimulus: send 0xA5 with stop bit low, then hold rx low 3 bit times, release, send 0x5A.
  - Required: frame_err single pulse, no rx_valid for 0xA5, busy stays 1 until line high, then 0x5A received.
- False start:
  - Stimulus: 0.25-bit low glitch on rx.
  - Required: return to IDLE, no rx_valid, no frame_err, busy=1 for at most CLKS_PER_BIT/2+3 cycles.
